// File: rtl/wb2axi4l_pkg.sv
// Shared types and constants for the Wishbone-classic to AXI4-Lite bridge.
package wb2axi4l_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/wb2axi4l_bridge.sv
// Wishbone classic slave to AXI4-Lite master, one outstanding transfer.
// Every Wishbone cycle becomes one AXI read or write and ends in ack or err.
module wb2axi4l_bridge
  import wb2axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  function automatic logic resp_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

  state_t                  state;
  logic                    abort;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [3:0]              sel_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aborting;

  assign m_axi_awaddr = adr_q;
  assign m_axi_araddr = adr_q;
  assign m_axi_wdata  = dat_q;
  assign m_axi_wstrb  = sel_q;
  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_arprot = PROT_DEFAULT;

  // A write channel is finished once its valid is gone or is being accepted now.
  assign aw_done  = !m_axi_awvalid || m_axi_awready;
  assign w_done   = !m_axi_wvalid  || m_axi_wready;
  assign aborting = abort || !wb_cyc_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      abort         <= 1'b0;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      wb_dat_o      <= '0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (state != IDLE && state != DONE && !wb_cyc_i) abort <= 1'b1;

      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
            abort <= 1'b0;
            if (wb_we_i) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            wb_ack_o     <= !aborting &&  resp_ok(m_axi_bresp);
            wb_err_o     <= !aborting && !resp_ok(m_axi_bresp);
            state        <= DONE;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (!aborting) wb_dat_o <= m_axi_rdata;
            wb_ack_o     <= !aborting &&  resp_ok(m_axi_rresp);
            wb_err_o     <= !aborting && !resp_ok(m_axi_rresp);
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
